// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the dual-port main memory controller.
//   state_t : controller FSM state (INIT clears the array, RUN serves requests)
//   lanes() : number of byte lanes in an N-bit word
package main_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int lanes(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-return pipeline for one memory port.
//   clk, rst : clock, synchronous active-high flush
//   rd_acc   : read accepted this cycle
//   ram_q    : RAM read register (valid the cycle after rd_acc)
//   rvalid   : one-cycle pulse, RD_LAT cycles after rd_acc
//   q        : read data, held between reads, 0 during reset
module mem_rd_pipe #(
  parameter int N      = 24,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_acc,
  input  logic [N-1:0] ram_q,
  output logic         rvalid,
  output logic [N-1:0] q
);

  logic [RD_LAT:1] vld_q;
  logic [RD_LAT:0] vld_pipe;
  logic [N-1:0]    q_hold;
  logic [N-1:0]    q_cur;

  assign vld_pipe = {vld_q, rd_acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      q_hold <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      // RAM data is present in stage 1; capture it so q holds between reads.
      if (vld_pipe[1]) q_hold <= ram_q;
    end
  end

  // With one cycle of latency the RAM register itself is the output stage,
  // so fresh data bypasses the hold register.
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign q_cur = vld_pipe[1] ? ram_q : q_hold;
    end else begin : g_lat2
      assign q_cur = q_hold;
    end
  endgenerate

  // Gating by rst keeps in-flight reads from surfacing in the reset cycle.
  assign rvalid = vld_pipe[RD_LAT] & ~rst;
  assign q      = rst ? '0 : q_cur;

endmodule

// File: rtl/main_mem_ctrl.sv
// Dual-port main memory controller: true-dual-port byte-writable RAM with a
// power-up clear sequence and per-port read-return pipelines.
//   clk, rst                 : clock, synchronous active-high reset
//   req_x, we_x, addr_x      : request valid, write(1)/read(0), word address
//   wdata_x, be_x            : write data, byte-lane enables
//   ready_x                  : port accepts requests (RUN only)
//   rvalid_x, q_x            : read-return pulse and data
//   init_done                : array cleared and usable
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int N              = 24,
  parameter int ADDR_W         = 19,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_a,
  input  logic                we_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [N-1:0]        wdata_a,
  input  logic [N/8-1:0]      be_a,
  input  logic                req_b,
  input  logic                we_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [N-1:0]        wdata_b,
  input  logic [N/8-1:0]      be_b,
  output logic                ready_a,
  output logic                ready_b,
  output logic                rvalid_a,
  output logic                rvalid_b,
  output logic [N-1:0]        q_a,
  output logic [N-1:0]        q_b,
  output logic                init_done
);

  localparam int NB    = lanes(N);
  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (CLEAR_ON_RESET == 0 || clr_cnt == '1) begin
            state <= ST_RUN;
            run_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state <= ST_INIT;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_a   = run_q & ~rst;
  assign ready_b   = run_q & ~rst;
  assign init_done = run_q & ~rst;

  logic acc_a, acc_b, rd_a, rd_b, clr;
  assign acc_a = req_a & ready_a;
  assign acc_b = req_b & ready_b;
  assign rd_a  = acc_a & ~we_a;
  assign rd_b  = acc_b & ~we_b;
  assign clr   = (state == ST_INIT) & ~rst & (CLEAR_ON_RESET != 0);

  // The clear sequence borrows port A's write path.
  logic              wa_en, wb_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [N-1:0]      wa_data;
  logic [NB-1:0]     wa_be;
  assign wa_en   = clr | (acc_a & we_a);
  assign wa_addr = clr ? clr_cnt : addr_a;
  assign wa_data = clr ? '0 : wdata_a;
  assign wa_be   = clr ? '1 : be_a;
  assign wb_en   = acc_b & we_b;

  logic [N-1:0] mem [0:DEPTH-1];
  logic [N-1:0] rq_a, rq_b;

  // Reads sample the pre-write contents (read-first). Port A's lane writes
  // come last so they take precedence on a same-address collision.
  always_ff @(posedge clk) begin
    if (rd_a) rq_a <= mem[addr_a];
    if (rd_b) rq_b <= mem[addr_b];
    for (int i = 0; i < NB; i++) begin
      if (wb_en && be_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
      if (wa_en && wa_be[i]) mem[wa_addr][8*i +: 8] <= wa_data[8*i +: 8];
    end
  end

  mem_rd_pipe #(.N(N), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk(clk), .rst(rst), .rd_acc(rd_a), .ram_q(rq_a), .rvalid(rvalid_a), .q(q_a)
  );

  mem_rd_pipe #(.N(N), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk(clk), .rst(rst), .rd_acc(rd_b), .ram_q(rq_b), .rvalid(rvalid_b), .q(q_b)
  );

endmodule

// File: tb/tb_main_mem_ctrl.sv
module tb_main_mem_ctrl;
  localparam int N = 24, AW = 4, NB = 3, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: RD_LAT=1
  logic rst, req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [N-1:0] wdata_a, wdata_b, q_a, q_b;
  logic [NB-1:0] be_a, be_b;
  logic ready_a, ready_b, rvalid_a, rvalid_b, init_done;

  // DUT 2: RD_LAT=2
  logic rst2, x_req_a, x_we_a, x_req_b, x_we_b;
  logic [AW-1:0] x_addr_a, x_addr_b;
  logic [N-1:0] x_wdata_a, x_wdata_b, x_q_a, x_q_b;
  logic [NB-1:0] x_be_a, x_be_b;
  logic x_ready_a, x_ready_b, x_rvalid_a, x_rvalid_b, x_init_done;

  main_mem_ctrl #(.N(N), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .be_a(be_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .be_b(be_b),
    .ready_a(ready_a), .ready_b(ready_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .q_a(q_a), .q_b(q_b), .init_done(init_done)
  );

  main_mem_ctrl #(.N(N), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst2),
    .req_a(x_req_a), .we_a(x_we_a), .addr_a(x_addr_a), .wdata_a(x_wdata_a), .be_a(x_be_a),
    .req_b(x_req_b), .we_b(x_we_b), .addr_b(x_addr_b), .wdata_b(x_wdata_b), .be_b(x_be_b),
    .ready_a(x_ready_a), .ready_b(x_ready_b), .rvalid_a(x_rvalid_a), .rvalid_b(x_rvalid_b),
    .q_a(x_q_a), .q_b(x_q_b), .init_done(x_init_done)
  );

  int checks = 0, failures = 0;
  logic [N-1:0] model [DEPTH];

  function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [N-1:0] nw,
                                         input logic [NB-1:0] be);
    logic [N-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; we_a = 0; req_b = 0; we_b = 0;
    x_req_a = 0; x_we_a = 0; x_req_b = 0; x_we_b = 0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1; rst2 = 1; idle();
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0; be_a = 0; be_b = 0;
    x_addr_a = 0; x_addr_b = 0; x_wdata_a = 0; x_wdata_b = 0; x_be_a = 0; x_be_b = 0;
    cyc(); cyc();
    checks++;
    if ({ready_a, ready_b, rvalid_a, rvalid_b, init_done} !== 5'b0 || q_a !== 0 || q_b !== 0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b%b rv=%b%b done=%b qa=%h qb=%h, want all 0",
               ready_a, ready_b, rvalid_a, rvalid_b, init_done, q_a, q_b);
    end
    checks++;
    if ({x_ready_a, x_ready_b, x_rvalid_a, x_rvalid_b, x_init_done} !== 5'b0 || x_q_a !== 0) begin
      failures++;
      $display("FAIL reset_outputs2: got rdy=%b%b rv=%b%b done=%b qa=%h, want all 0",
               x_ready_a, x_ready_b, x_rvalid_a, x_rvalid_b, x_init_done, x_q_a);
    end
    // release, then reset again mid-clear: the clear must restart from 0
    rst = 0; rst2 = 0;
    for (int k = 0; k < 5; k++) cyc();
    rst = 1; cyc(); rst = 0;
    // write attempt during INIT must be ignored
    req_a = 1; we_a = 1; addr_a = 0; wdata_a = 24'hFFFFFF; be_a = 3'b111;
    n = 0;
    while (!ready_a && n < 40) begin cyc(); n++; end
    idle();
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL init_length: got %0d not-ready cycles, want 16", n);
    end
    checks++;
    if (init_done !== 1'b1 || ready_b !== 1'b1) begin
      failures++;
      $display("FAIL init_done: got done=%b ready_b=%b, want 1 1", init_done, ready_b);
    end
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
  endtask

  task automatic test_clear_readback();
    for (int k = 0; k < DEPTH; k++) begin
      req_a = 1; we_a = 0; addr_a = AW'(k);
      req_b = 1; we_b = 0; addr_b = AW'(DEPTH - 1 - k);
      cyc();
      checks++;
      if (rvalid_a !== 1'b1 || q_a !== model[k] || rvalid_b !== 1'b1 || q_b !== model[DEPTH-1-k]) begin
        failures++;
        $display("FAIL clear_read[%0d]: got rv=%b%b qa=%h qb=%h, want rv=11 qa=%h qb=%h",
                 k, rvalid_a, rvalid_b, q_a, q_b, model[k], model[DEPTH-1-k]);
      end
    end
    idle(); cyc();
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || q_a !== 24'h0) begin
      failures++;
      $display("FAIL read_idle_hold: got rv=%b%b qa=%h, want rv=00 qa=000000", rvalid_a, rvalid_b, q_a);
    end
  endtask

  task automatic test_byte_write();
    req_a = 1; we_a = 1; addr_a = 3; wdata_a = 24'hABCDEF; be_a = 3'b101;
    model[3] = merge(model[3], 24'hABCDEF, 3'b101);
    cyc(); idle();
    checks++;
    if (rvalid_a !== 1'b0 || q_a !== 24'h0) begin
      failures++;
      $display("FAIL write_no_rvalid: got rv=%b qa=%h, want rv=0 qa=000000", rvalid_a, q_a);
    end
    req_a = 1; we_a = 0; addr_a = 3;
    cyc(); idle();
    checks++;
    if (rvalid_a !== 1'b1 || q_a !== 24'hAB00EF || q_a !== model[3]) begin
      failures++;
      $display("FAIL byte_write: got rv=%b qa=%h, want rv=1 qa=ab00ef", rvalid_a, q_a);
    end
    cyc();
    checks++;
    if (rvalid_a !== 1'b0 || q_a !== 24'hAB00EF) begin
      failures++;
      $display("FAIL rvalid_pulse: got rv=%b qa=%h, want rv=0 qa=ab00ef", rvalid_a, q_a);
    end
  endtask

  task automatic test_ww_collision();
    req_a = 1; we_a = 1; addr_a = 5; wdata_a = 24'h111111; be_a = 3'b011;
    req_b = 1; we_b = 1; addr_b = 5; wdata_b = 24'h222222; be_b = 3'b110;
    model[5] = merge(merge(model[5], 24'h222222, 3'b110), 24'h111111, 3'b011);
    cyc(); idle();
    req_b = 1; we_b = 0; addr_b = 5;
    cyc(); idle();
    checks++;
    if (rvalid_b !== 1'b1 || q_b !== 24'h221111 || q_b !== model[5]) begin
      failures++;
      $display("FAIL ww_collision: got rv=%b qb=%h, want rv=1 qb=221111", rvalid_b, q_b);
    end
  endtask

  task automatic test_rw_collision();
    req_a = 1; we_a = 1; addr_a = 7; wdata_a = 24'h000055; be_a = 3'b111;
    cyc();
    wdata_a = 24'h0000AA;
    req_b = 1; we_b = 0; addr_b = 7;
    cyc(); idle();
    checks++;
    if (rvalid_b !== 1'b1 || q_b !== 24'h000055) begin
      failures++;
      $display("FAIL rw_collision_old: got rv=%b qb=%h, want rv=1 qb=000055", rvalid_b, q_b);
    end
    req_b = 1; we_b = 0; addr_b = 7;
    cyc(); idle();
    model[7] = 24'h0000AA;
    checks++;
    if (rvalid_b !== 1'b1 || q_b !== 24'h0000AA) begin
      failures++;
      $display("FAIL rw_collision_new: got rv=%b qb=%h, want rv=1 qb=0000aa", rvalid_b, q_b);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] hold_a, hold_b;
    logic ra, rb;
    hold_a = 24'hAB00EF; hold_b = 24'h0000AA;
    for (int i = 0; i < 300; i++) begin
      req_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
      req_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      addr_a = AW'($urandom_range(0, DEPTH - 1));
      addr_b = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, DEPTH - 1));
      wdata_a = N'($urandom); wdata_b = N'($urandom);
      be_a = NB'($urandom_range(0, 7)); be_b = NB'($urandom_range(0, 7));
      ra = req_a & ~we_a; rb = req_b & ~we_b;
      if (ra) hold_a = model[addr_a];
      if (rb) hold_b = model[addr_b];
      if (req_b && we_b) model[addr_b] = merge(model[addr_b], wdata_b, be_b);
      if (req_a && we_a) model[addr_a] = merge(model[addr_a], wdata_a, be_a);
      cyc();
      checks++;
      if (rvalid_a !== ra || q_a !== hold_a || rvalid_b !== rb || q_b !== hold_b) begin
        failures++;
        $display("FAIL random[%0d]: got rv=%b%b qa=%h qb=%h, want rv=%b%b qa=%h qb=%h",
                 i, rvalid_a, rvalid_b, q_a, q_b, ra, rb, hold_a, hold_b);
      end
    end
    idle(); cyc();
  endtask

  task automatic test_lat2_flush();
    int n;
    bit pulse;
    for (int k = 1; k <= 3; k++) begin
      x_req_a = 1; x_we_a = 1; x_addr_a = AW'(k); x_wdata_a = 24'h123450 + N'(k); x_be_a = 3'b111;
      cyc();
    end
    idle();
    x_req_b = 1; x_we_b = 0; x_addr_b = 1;
    cyc();
    checks++;
    if (x_rvalid_b !== 1'b0) begin
      failures++;
      $display("FAIL lat2_early: got rv=%b one cycle after read, want 0", x_rvalid_b);
    end
    x_addr_b = 2;
    cyc();
    checks++;
    if (x_rvalid_b !== 1'b1 || x_q_b !== 24'h123451) begin
      failures++;
      $display("FAIL lat2_pulse: got rv=%b qb=%h, want rv=1 qb=123451", x_rvalid_b, x_q_b);
    end
    x_addr_b = 3;
    cyc();
    rst2 = 1; idle();
    #1;
    checks++;
    if (x_rvalid_b !== 1'b0 || x_ready_b !== 1'b0) begin
      failures++;
      $display("FAIL lat2_flush: got rv=%b ready=%b during reset, want 0 0", x_rvalid_b, x_ready_b);
    end
    cyc();
    rst2 = 0;
    n = 0; pulse = 0;
    while (!x_ready_b && n < 40) begin
      cyc(); n++;
      if (x_rvalid_b || x_rvalid_a) pulse = 1;
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (x_rvalid_b || x_rvalid_a) pulse = 1;
    end
    checks++;
    if (pulse !== 1'b0) begin
      failures++;
      $display("FAIL lat2_stale_pulse: got a pulse after reset, want none");
    end
    checks++;
    if (n !== 16 || x_init_done !== 1'b1) begin
      failures++;
      $display("FAIL lat2_reinit: got %0d init cycles done=%b, want 16 1", n, x_init_done);
    end
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_byte_write();
    test_ww_collision();
    test_rw_collision();
    test_random();
    test_lat2_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 SHALL have parameter N, default 24: data word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 19: address width; depth = 2^ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles, legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1: zero-fill the array after reset.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports req_a / req_b, input, 1: request valid.
REQ-008 SHALL have ports we_a / we_b, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have ports addr_a / addr_b, input, ADDR_W: word address.
REQ-010 SHALL have ports wdata_a / wdata_b, input, N: write data.
REQ-011 SHALL have ports be_a / be_b, input, N/8: byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-012 SHALL have ports ready_a / ready_b, output, 1: port accepts requests.
REQ-013 SHALL have ports rvalid_a / rvalid_b, output, 1: one-cycle pulse marking read data valid.
REQ-014 SHALL have ports q_a / q_b, output, N: read data.
REQ-015 SHALL have port init_done, output, 1: high once the array is usable.

Function
REQ-016 SHALL implement a two-state FSM: INIT and RUN.
REQ-017 In INIT, SHALL hold a clear counter starting at 0, write 0 to word[counter] each cycle, and increment the counter.
REQ-018 In INIT, SHALL move to RUN in the cycle after the write to address 2^ADDR_W-1.
REQ-019 With CLEAR_ON_RESET=0, SHALL enter RUN in the first cycle after rst deasserts; array contents stay undefined.
REQ-020 ready_x SHALL be 0 in INIT and 1 in RUN; init_done SHALL equal (state==RUN).
REQ-021 A request SHALL be accepted only in a cycle where req_x=1 and ready_x=1; requests while ready_x=0 SHALL be ignored, not queued.
REQ-022 An accepted write SHALL update only the byte lanes whose be_x bit is 1; be_x=0 SHALL leave the word unchanged.
REQ-023 An accepted read SHALL drive q_x and pulse rvalid_x exactly RD_LAT cycles after acceptance (RD_LAT=2 adds one output register stage).
REQ-024 q_x SHALL hold its last read value between reads; writes SHALL never alter q_x and SHALL never raise rvalid_x.
REQ-025 Back-to-back reads on one port SHALL be accepted every cycle, giving one rvalid_x per read, in order.
REQ-026 Write/write collision (same address, same cycle): for lanes enabled on both ports, port A's data SHALL win; lanes enabled on only one port SHALL take that port's data.
REQ-027 Read/write collision (same address, same cycle, opposite ports): the read SHALL return the old (pre-write) data.
REQ-028 Reads on both ports to the same address in the same cycle SHALL both return the same stored word.

Reset
REQ-029 While rst=1: state=INIT, counter=0, ready_x=0, rvalid_x=0, q_x=0, init_done=0.
REQ-030 Asserting rst mid-operation SHALL flush the read pipeline; no rvalid_x pulse SHALL appear for reads accepted before rst.
REQ-031 Asserting rst mid-INIT SHALL restart the clear from address 0.
REQ-032 The array itself SHALL NOT be reset except through the INIT clear.

Structure
REQ-033 Package main_mem_pkg SHALL hold the FSM state enum typedef (ST_INIT, ST_RUN) and the lane-count constant function (N/8).
REQ-034 Sub-module mem_rd_pipe SHALL be instantiated once per port: an RD_LAT-deep valid/data register pipeline with synchronous flush.
REQ-035 The array SHALL be a single true-dual-port inferred block RAM; the INIT clear SHALL reuse port A's write path.

Verification (bench: N=24, ADDR_W=4, RD_LAT=1 unless stated)
REQ-036 Reset release -> ready_a=ready_b=0 for exactly 16 cycles, then init_done=1; reads of all 16 addresses return 0x000000.
REQ-037 A writes 0xABCDEF to addr 3 with be=3'b101, then A reads addr 3 -> q_a=0xAB00EF with rvalid_a pulsed one cycle after the read.
REQ-038 Same cycle: A writes 0x111111 (be=3'b011) and B writes 0x222222 (be=3'b110) to addr 5 -> a later read returns 0x221111.
REQ-039 Addr 7 holds 0x000055; same cycle A writes 0x0000AA to addr 7 while B reads addr 7 -> q_b=0x000055; next read returns 0x0000AA.
REQ-040 RD_LAT=2: B issues reads of addrs 1,2,3 in consecutive cycles, then rst is asserted one cycle after the last read -> rvalid_b pulses for addr 1 only, two cycles after its read; no further pulses; INIT restarts.
REQ-041 req_a=1 during INIT with a write of 0xFFFFFF to addr 0 -> write ignored; after INIT, addr 0 reads 0x000000.
